// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control decoder with a multi-cycle MULT/DIV sequencer.
// Define ALU_CTRL_MDU_EN to enable the MULT/DIV/MFHI/MFLO decodes and the MDU handshake outputs.
module alu_control_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        alu_op_i,
  input  logic [5:0]        alu_function_i,
  output logic [CTRL_W-1:0] alu_operation_o,
  output logic              op_valid_o,
  output logic              illegal_o,
  output logic              mdu_start_o,
  output logic              mdu_signed_o,
  output logic              mdu_busy_o,
  output logic              hilo_we_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CTRL_W-1:0] r_op;
  logic              r_op_valid;
  logic              r_illegal;
  logic              r_start;
  logic              r_signed;
  logic              r_busy;
  logic              r_hilo;

  logic [3:0] w_op;
  logic       w_illegal;
  logic       w_multi;
  logic       w_signed;
  logic       w_div;
  logic       w_accept;

`ifdef ALU_CTRL_MDU_EN
  assign ready_o = !reset && (r_state != S_BUSY);
`else
  assign ready_o = !reset;
`endif

  assign w_accept = valid_i && ready_o;

  // Selector decode; unmatched selectors fall through to the illegal code.
  always_comb begin
    w_op      = 4'b1001;
    w_illegal = 1'b1;
    w_multi   = 1'b0;
    w_signed  = 1'b0;
    w_div     = 1'b0;
    case (alu_op_i)
      3'b111: begin
        w_illegal = 1'b0;
        case (alu_function_i)
          6'b100000: w_op = 4'b0011;
          6'b100001: w_op = 4'b0011;
          6'b100010: w_op = 4'b0100;
          6'b100100: w_op = 4'b0000;
          6'b100101: w_op = 4'b0001;
          6'b100111: w_op = 4'b0010;
          6'b101010: w_op = 4'b0101;
          6'b000000: w_op = 4'b0110;
          6'b000010: w_op = 4'b0111;
`ifdef ALU_CTRL_MDU_EN
          6'b010000: w_op = 4'b1100;
          6'b010010: w_op = 4'b1101;
          6'b011000: begin w_op = 4'b1010; w_multi = 1'b1; w_signed = 1'b1; end
          6'b011001: begin w_op = 4'b1010; w_multi = 1'b1; end
          6'b011010: begin w_op = 4'b1011; w_multi = 1'b1; w_signed = 1'b1; w_div = 1'b1; end
          6'b011011: begin w_op = 4'b1011; w_multi = 1'b1; w_div = 1'b1; end
`endif
          default: begin
            w_op      = 4'b1001;
            w_illegal = 1'b1;
          end
        endcase
      end
      3'b100:  begin w_op = 4'b0011; w_illegal = 1'b0; end
      3'b001:  begin w_op = 4'b0001; w_illegal = 1'b0; end
      3'b010:  begin w_op = 4'b0000; w_illegal = 1'b0; end
      3'b011:  begin w_op = 4'b1000; w_illegal = 1'b0; end
      3'b101:  begin w_op = 4'b0100; w_illegal = 1'b0; end
      3'b110:  begin w_op = 4'b0011; w_illegal = 1'b0; end
      default: begin w_op = 4'b1001; w_illegal = 1'b1; end
    endcase
  end

  // Sequencer next state; DONE accepts exactly like IDLE so a new MDU op can chain directly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_BUSY: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_IDLE, S_DONE: begin
        if (w_accept && w_multi) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; decoded fields only update on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_op       <= {CTRL_W{1'b0}};
      r_op_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_start    <= 1'b0;
      r_signed   <= 1'b0;
      r_busy     <= 1'b0;
      r_hilo     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op_valid <= w_accept;
      r_start    <= w_accept && w_multi;
      r_busy     <= (w_state_nxt == S_BUSY);
      r_hilo     <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op      <= CTRL_W'(w_op);
        r_illegal <= w_illegal;
        r_signed  <= w_signed;
      end
    end
  end

  assign alu_operation_o = r_op;
  assign op_valid_o      = r_op_valid;
  assign illegal_o       = r_illegal;
  assign mdu_start_o     = r_start;
  assign mdu_signed_o    = r_signed;
  assign mdu_busy_o      = r_busy;
  assign hilo_we_o       = r_hilo;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq; MDU scenarios run when ALU_CTRL_MDU_EN is defined.
module tb_alu_control_seq;

  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [2:0] alu_op_i = 3'b000;
  logic [5:0] alu_function_i = 6'b000000;
  logic [3:0] alu_operation_o;
  logic       op_valid_o, illegal_o, mdu_start_o, mdu_signed_o, mdu_busy_o, hilo_we_o;

  typedef struct packed {
    logic [3:0] op;
    logic       ill;
    logic       start;
    logic       sgn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_control_seq #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .alu_function_i(alu_function_i),
    .alu_operation_o(alu_operation_o), .op_valid_o(op_valid_o), .illegal_o(illegal_o),
    .mdu_start_o(mdu_start_o), .mdu_signed_o(mdu_signed_o),
    .mdu_busy_o(mdu_busy_o), .hilo_we_o(hilo_we_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [3:0] eop, input logic eill,
                       input logic estart, input logic esgn);
    exp_t e;
    alu_op_i       = op;
    alu_function_i = fn;
    valid_i        = 1'b1;
    if (ready_o) begin
      e = '{op: eop, ill: eill, start: estart, sgn: esgn};
      exp_q.push_back(e);
    end
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: compare each op_valid_o pulse against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (op_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious op_valid", {31'd0, op_valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("alu_operation", {28'd0, alu_operation_o}, {28'd0, e.op});
          chk("illegal", {31'd0, illegal_o}, {31'd0, e.ill});
          chk("mdu_start", {31'd0, mdu_start_o}, {31'd0, e.start});
          if (e.start) chk("mdu_signed", {31'd0, mdu_signed_o}, {31'd0, e.sgn});
        end
      end else begin
        chk("start without op_valid", {31'd0, mdu_start_o}, 32'd0);
      end
`ifndef ALU_CTRL_MDU_EN
      chk("mdu_busy tied", {31'd0, mdu_busy_o}, 32'd0);
      chk("hilo_we tied", {31'd0, hilo_we_o}, 32'd0);
      chk("ready never drops", {31'd0, ready_o}, {31'd0, !reset});
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_hilo;
    repeat (2) step();
    chk("reset ready", {31'd0, ready_o}, 32'd0);
    chk("reset outputs", {25'd0, alu_operation_o, op_valid_o, illegal_o, mdu_start_o},
        32'd0);
    chk("reset mdu outputs", {29'd0, mdu_signed_o, mdu_busy_o, hilo_we_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after reset", {31'd0, ready_o}, 32'd1);

    issue(3'b111, 6'b100000, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("ready after ADD", {31'd0, ready_o}, 32'd1);

    // Back-to-back I-type, I-type, illegal.
    issue(3'b100, 6'b101010, 4'b0011, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 6'b111111, 4'b0001, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 6'b000001, 4'b1001, 1'b1, 1'b0, 1'b0);
    step();
    chk("hold operation", {28'd0, alu_operation_o}, 32'h9);
    chk("hold illegal", {31'd0, illegal_o}, 32'd1);
    chk("op_valid idle", {31'd0, op_valid_o}, 32'd0);

    issue(3'b111, 6'b100001, 4'b0011, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b100100, 4'b0000, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b100101, 4'b0001, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b100111, 4'b0010, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b101010, 4'b0101, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b000000, 4'b0110, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b000010, 4'b0111, 1'b0, 1'b0, 1'b0);
    issue(3'b010, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0);
    issue(3'b011, 6'b010101, 4'b1000, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 6'b000011, 4'b0100, 1'b0, 1'b0, 1'b0);
    issue(3'b110, 6'b110000, 4'b0011, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b000001, 4'b1001, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 6'b101011, 4'b1001, 1'b1, 1'b0, 1'b0);
    step();

`ifdef ALU_CTRL_MDU_EN
    issue(3'b111, 6'b010000, 4'b1100, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 6'b010010, 4'b1101, 1'b0, 1'b0, 1'b0);

    // MULT, with a DIVU held on valid_i during BUSY and accepted in DONE.
    issue(3'b111, 6'b011000, 4'b1010, 1'b0, 1'b1, 1'b1);
    alu_op_i = 3'b111;
    alu_function_i = 6'b011011;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mult busy ready", {31'd0, ready_o}, 32'd0);
      chk("mult busy", {31'd0, mdu_busy_o}, 32'd1);
      chk("mult busy hilo", {31'd0, hilo_we_o}, 32'd0);
      step();
    end
    chk("mult done hilo", {31'd0, hilo_we_o}, 32'd1);
    chk("mult done ready", {31'd0, ready_o}, 32'd1);
    chk("mult done busy", {31'd0, mdu_busy_o}, 32'd0);
    exp_q.push_back('{op: 4'b1011, ill: 1'b0, start: 1'b1, sgn: 1'b0});
    step();
    valid_i = 1'b0;
    chk("divu hilo pulse ends", {31'd0, hilo_we_o}, 32'd0);
    for (int i = 0; i < DIV_LAT; i++) begin
      chk("divu busy", {31'd0, mdu_busy_o}, 32'd1);
      chk("divu busy ready", {31'd0, ready_o}, 32'd0);
      step();
    end
    chk("divu done hilo", {31'd0, hilo_we_o}, 32'd1);
    chk("divu done ready", {31'd0, ready_o}, 32'd1);
    chk("divu done busy", {31'd0, mdu_busy_o}, 32'd0);
    step();
    chk("idle hilo", {31'd0, hilo_we_o}, 32'd0);
    chk("idle ready", {31'd0, ready_o}, 32'd1);

    // Reset in the second BUSY cycle of DIV aborts it.
    issue(3'b111, 6'b011010, 4'b1011, 1'b0, 1'b1, 1'b1);
    step();
    chk("div 2nd busy", {31'd0, mdu_busy_o}, 32'd1);
    reset = 1'b1;
    step();
    chk("abort outputs", {25'd0, alu_operation_o, op_valid_o, illegal_o, mdu_start_o},
        32'd0);
    chk("abort mdu outputs", {29'd0, mdu_signed_o, mdu_busy_o, hilo_we_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort ready", {31'd0, ready_o}, 32'd1);
    seen_hilo = 1'b0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      seen_hilo = seen_hilo | hilo_we_o | mdu_busy_o;
      step();
    end
    chk("no hilo after abort", {31'd0, seen_hilo}, 32'd0);
`else
    issue(3'b111, 6'b011000, 4'b1001, 1'b1, 1'b0, 1'b0);
    chk("mult ready stays", {31'd0, ready_o}, 32'd1);
    issue(3'b111, 6'b011001, 4'b1001, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 6'b011010, 4'b1001, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 6'b011011, 4'b1001, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 6'b010000, 4'b1001, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 6'b010010, 4'b1001, 1'b1, 1'b0, 1'b0);
    seen_hilo = 1'b0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      seen_hilo = seen_hilo | hilo_we_o | mdu_busy_o | !ready_o;
      step();
    end
    chk("no mdu activity", {31'd0, seen_hilo}, 32'd0);
`endif

    repeat (3) step();
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
